cb_param_ctrl: RTL and testbench
================================

Name: cb_param_ctrl

Overview:
Runtime controller for the contrast/brightness pixel stage. Holds target contrast and brightness values, which can be set by four button pulses or by a host register-write handshake. Commits targets to the datapath only at frame boundaries (vsync rising edge), so a frame is never processed with mixed settings. Sits between the user-input/host logic and the contrast/brightness stage's contrast and brightness operands.

Parameters:
CONTRAST_DEF, 4, reset contrast (4 = unity gain; datapath computes pixel*contrast/4)
BRIGHT_DEF, 32, reset brightness offset
CONTRAST_MAX, 16, saturation ceiling for contrast
BRIGHT_MAX, 255, saturation ceiling for brightness
STEP, 1, increment per button pulse; also per-frame ramp step when CB_RAMP_EN is defined

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
vsync  in  1  frame sync level, synchronous to clk; rising edge = frame boundary
btn_c_up  in  1  single-cycle pulse, contrast += STEP
btn_c_dn  in  1  single-cycle pulse, contrast -= STEP
btn_b_up  in  1  single-cycle pulse, brightness += STEP
btn_b_dn  in  1  single-cycle pulse, brightness -= STEP
host_req  in  1  host write request, held high until host_ack is seen
host_contrast  in  8  host contrast value
host_bright  in  8  host brightness value
host_ack  out  1  one-cycle pulse, host write captured
contrast  out  8  committed contrast to datapath
brightness  out  8  committed brightness to datapath
busy  out  1  high when targets differ from committed values
frame_apply  out  1  one-cycle pulse on the cycle the outputs change

Behaviour:
- Reset (reset low, asynchronous):
  - contrast and target contrast = CONTRAST_DEF; brightness and target brightness = BRIGHT_DEF.
  - host_ack = 0, frame_apply = 0, busy = 0, state = IDLE.
  - vsync_d = 1, so a vsync held high through reset release does not count as an edge.
  - req_armed = 1.
- Edge detect: vsync_rise = vsync & ~vsync_d, with vsync_d registered every cycle.
- Target update priority, per cycle:
  - Host capture first: host_req & req_armed → targets <= min(host value, MAX); host_ack = 1 on the next cycle; req_armed <= 0. Button pulses in the same cycle are dropped.
  - req_armed returns to 1 only after a cycle with host_req low. A held request produces exactly one ack.
  - Otherwise buttons act per channel, independently:
    - up only: target = min(target + STEP, MAX)
    - dn only: target = max(target - STEP, 0), with no underflow wrap
    - up and dn together: target unchanged
  - Arithmetic uses 9-bit intermediates before clamping.
- FSM:
  - IDLE: outputs equal targets. Go to PENDING when any target differs from its output.
  - PENDING: wait for vsync_rise, then go to APPLY.
  - APPLY (one cycle): load contrast/brightness from targets and pulse frame_apply. Next state is PENDING if targets changed during APPLY, else IDLE.
  - A target returning to the committed value while in PENDING sends the FSM to IDLE with no frame_apply.
- busy = (state != IDLE).
- Latency: a button or host capture at cycle t commits at the first vsync_rise after t+1. frame_apply and the new outputs appear the cycle after that edge.
- vsync_rise in IDLE: no effect.
- Reset mid-operation: pending targets are discarded and defaults restored immediately.

Optional Feature:
CB_RAMP_EN:
- Defined: APPLY moves each output toward its target by at most STEP per vsync_rise. After APPLY, the FSM returns to PENDING until outputs equal targets, with frame_apply pulsing on each frame that changes a value. Gives gradual fades.
- Undefined: APPLY loads targets directly in one frame.

Test Plan:
- Reset release with vsync held high → contrast=4, brightness=32, busy=0; no frame_apply until vsync falls and rises again.
- btn_b_up ×3, then one vsync rise → brightness stays 32 until the edge; 35 one cycle after it; frame_apply pulses once; busy returns to 0.
- host_req held 10 cycles with contrast=200, bright=10, plus btn_c_up in the capture cycle → exactly one host_ack; target contrast=16 (clamped); button ignored; contrast=16 after the next vsync.
- Brightness 0, then btn_b_dn → stays 0 with busy=0. Contrast 16, then btn_c_up and btn_c_dn in the same cycle → unchanged.
- btn_c_up then btn_c_dn before any vsync → busy rises then falls; no frame_apply on the next vsync.
- CB_RAMP_EN defined, host sets brightness 32→36 → brightness reads 33, 34, 35, 36 on four successive frames with four frame_apply pulses; busy high until the 4th frame.

Source files
------------

// File: rtl/cb_param_ctrl.sv
// Contrast/brightness runtime controller: buttons or host set targets, vsync rising edge commits them.
// Optional CB_RAMP_EN: outputs fade toward targets by STEP per frame instead of jumping in one frame.
module cb_param_ctrl #(
    parameter int CONTRAST_DEF = 4,
    parameter int BRIGHT_DEF   = 32,
    parameter int CONTRAST_MAX = 16,
    parameter int BRIGHT_MAX   = 255,
    parameter int STEP         = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       btn_c_up,
    input  logic       btn_c_dn,
    input  logic       btn_b_up,
    input  logic       btn_b_dn,
    input  logic       host_req,
    input  logic [7:0] host_contrast,
    input  logic [7:0] host_bright,
    output logic       host_ack,
    output logic [7:0] contrast,
    output logic [7:0] brightness,
    output logic       busy,
    output logic       frame_apply
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    localparam logic [8:0] STEP9   = 9'(STEP);
    localparam logic [8:0] C_MAX9  = 9'(CONTRAST_MAX);
    localparam logic [8:0] B_MAX9  = 9'(BRIGHT_MAX);
    localparam logic [7:0] C_DEF8  = 8'(CONTRAST_DEF);
    localparam logic [7:0] B_DEF8  = 8'(BRIGHT_DEF);

    state_t     state_q, state_d;
    logic       vsync_d_q;
    logic       req_armed_q, req_armed_d;
    logic       host_ack_q, host_ack_d;
    logic [7:0] tgt_c_q, tgt_c_d;
    logic [7:0] tgt_b_q, tgt_b_d;
    logic [7:0] con_q, con_d;
    logic [7:0] bri_q, bri_d;

    logic vsync_rise;
    logic host_cap;
    logic differ;

    function automatic logic [7:0] clamp_host(input logic [7:0] val, input logic [8:0] max);
        return ({1'b0, val} > max) ? max[7:0] : val;
    endfunction

    function automatic logic [7:0] step_chan(input logic [7:0] cur, input logic up,
                                             input logic dn, input logic [8:0] max);
        logic [8:0] cur9;
        logic [8:0] sum9;
        cur9 = {1'b0, cur};
        sum9 = cur9 + STEP9;
        if (up && !dn) begin
            return (sum9 > max) ? max[7:0] : sum9[7:0];
        end else if (dn && !up) begin
            return (cur9 < STEP9) ? 8'd0 : 8'(cur9 - STEP9);
        end
        return cur;
    endfunction

`ifdef CB_RAMP_EN
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return (diff > STEP9) ? 8'({1'b0, cur} + STEP9) : tgt;
        end else if (tgt < cur) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            return (diff > STEP9) ? 8'({1'b0, cur} - STEP9) : tgt;
        end
        return cur;
    endfunction
`endif

    assign vsync_rise = vsync & ~vsync_d_q;
    assign host_cap   = host_req & req_armed_q;
    assign differ     = (tgt_c_q != con_q) || (tgt_b_q != bri_q);

    // Re-arms only after a cycle with host_req low, so a held request is captured once.
    assign req_armed_d = ~host_req;
    assign host_ack_d  = host_cap;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tgt_c_d = tgt_c_q;
        tgt_b_d = tgt_b_q;
        if (host_cap) begin
            tgt_c_d = clamp_host(host_contrast, C_MAX9);
            tgt_b_d = clamp_host(host_bright, B_MAX9);
        end else begin
            tgt_c_d = step_chan(tgt_c_q, btn_c_up, btn_c_dn, C_MAX9);
            tgt_b_d = step_chan(tgt_b_q, btn_b_up, btn_b_dn, B_MAX9);
        end
    end

    // Outputs load on the transition into APPLY, so frame_apply coincides with the new values.
    always_comb begin
        state_d = state_q;
        con_d   = con_q;
        bri_d   = bri_q;
        unique case (state_q)
            IDLE: begin
                if (differ) state_d = PENDING;
            end
            PENDING: begin
                if (!differ) begin
                    state_d = IDLE;
                end else if (vsync_rise) begin
                    state_d = APPLY;
`ifdef CB_RAMP_EN
                    con_d = ramp_toward(con_q, tgt_c_q);
                    bri_d = ramp_toward(bri_q, tgt_b_q);
`else
                    con_d = tgt_c_q;
                    bri_d = tgt_b_q;
`endif
                end
            end
            APPLY: begin
                state_d = differ ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vsync_d_q   <= 1'b1;
            req_armed_q <= 1'b1;
            host_ack_q  <= 1'b0;
            tgt_c_q     <= C_DEF8;
            tgt_b_q     <= B_DEF8;
            con_q       <= C_DEF8;
            bri_q       <= B_DEF8;
        end else begin
            state_q     <= state_d;
            vsync_d_q   <= vsync;
            req_armed_q <= req_armed_d;
            host_ack_q  <= host_ack_d;
            tgt_c_q     <= tgt_c_d;
            tgt_b_q     <= tgt_b_d;
            con_q       <= con_d;
            bri_q       <= bri_d;
        end
    end

    assign host_ack    = host_ack_q;
    assign contrast    = con_q;
    assign brightness  = bri_q;
    assign busy        = (state_q != IDLE);
    assign frame_apply = (state_q == APPLY);

endmodule

// File: tb/tb_cb_param_ctrl.sv
// Self-checking bench for cb_param_ctrl: per-scenario tasks plus a scoreboard of committed values.
module tb_cb_param_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       btn_c_up, btn_c_dn, btn_b_up, btn_b_dn;
    logic       host_req;
    logic [7:0] host_contrast, host_bright;
    logic       host_ack;
    logic [7:0] contrast, brightness;
    logic       busy, frame_apply;

    int tests = 0;
    int fails = 0;
    int apply_cnt = 0;

    // Reference model: targets (m_*) and committed outputs (o_*).
    int m_c, m_b, o_c, o_b;
    logic [15:0] exp_q[$];

    cb_param_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .btn_c_up     (btn_c_up),
        .btn_c_dn     (btn_c_dn),
        .btn_b_up     (btn_b_up),
        .btn_b_dn     (btn_b_dn),
        .host_req     (host_req),
        .host_contrast(host_contrast),
        .host_bright  (host_bright),
        .host_ack     (host_ack),
        .contrast     (contrast),
        .brightness   (brightness),
        .busy         (busy),
        .frame_apply  (frame_apply)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard: each frame_apply pulse pops the expected committed pair.
    always @(negedge clk) begin
        if (reset && frame_apply) begin
            logic [15:0] e;
            apply_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_apply: got c=%0d b=%0d, required no frame_apply", contrast, brightness);
            end else begin
                e = exp_q.pop_front();
                if ({contrast, brightness} !== e) begin
                    fails++;
                    $display("FAIL sb_commit: got c=%0d b=%0d, required c=%0d b=%0d",
                             contrast, brightness, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic int ramp_step(input int o, input int t);
`ifdef CB_RAMP_EN
        if (t > o) return o + 1;
        if (t < o) return o - 1;
        return o;
`else
        return t;
`endif
    endfunction

    // One frame boundary: vsync low, then rising edge, then settle.
    task automatic frame();
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        if (m_c != o_c || m_b != o_b) begin
            o_c = ramp_step(o_c, m_c);
            o_b = ramp_step(o_b, m_b);
            exp_q.push_back({8'(o_c), 8'(o_b)});
        end
        repeat (4) tick();
    endtask

    task automatic pulse(input int which);
        btn_c_up = (which == 0);
        btn_c_dn = (which == 1);
        btn_b_up = (which == 2);
        btn_b_dn = (which == 3);
        tick();
        {btn_c_up, btn_c_dn, btn_b_up, btn_b_dn} = 4'b0;
    endtask

    task automatic host_write(input int c, input int b);
        host_contrast = 8'(c);
        host_bright   = 8'(b);
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        tick();
        m_c = (c > 16) ? 16 : c;
        m_b = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        vsync = 1'b1;
        {btn_c_up, btn_c_dn, btn_b_up, btn_b_dn} = 4'b0;
        host_req = 1'b0;
        host_contrast = 8'd0;
        host_bright = 8'd0;
        m_c = 4; m_b = 32; o_c = 4; o_b = 32;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("reset_contrast", contrast, 4);
        chk("reset_brightness", brightness, 32);
        chk("reset_busy", busy, 0);
        chk("reset_ack", host_ack, 0);
        chk("reset_apply_count", apply_cnt, 0);
        frame();
        chk("reset_idle_frame_apply_count", apply_cnt, 0);
    endtask

    task automatic test_bright_buttons();
        int a0;
        a0 = apply_cnt;
        repeat (3) begin
            pulse(2);
            tick();
            m_b++;
        end
        chk("btn_busy_pending", busy, 1);
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        o_b = ramp_step(o_b, m_b);
        exp_q.push_back({8'(o_c), 8'(o_b)});
        chk("btn_before_edge", brightness, 32);
        tick();
`ifndef CB_RAMP_EN
        chk("btn_after_edge", brightness, 35);
`endif
        chk("btn_frame_apply", frame_apply, 1);
        repeat (3) tick();
`ifdef CB_RAMP_EN
        frame();
        frame();
`endif
        chk("btn_busy_done", busy, 0);
        chk("btn_final_brightness", brightness, 35);
`ifdef CB_RAMP_EN
        chk("btn_apply_pulses", apply_cnt - a0, 3);
`else
        chk("btn_apply_pulses", apply_cnt - a0, 1);
`endif
    endtask

    task automatic test_host_capture();
        int acks;
        host_contrast = 8'd200;
        host_bright   = 8'd10;
        host_req = 1'b1;
        btn_c_up = 1'b1;
        tick();
        btn_c_up = 1'b0;
        acks = int'(host_ack);
        repeat (9) begin
            tick();
            acks += int'(host_ack);
        end
        host_req = 1'b0;
        repeat (2) begin
            tick();
            acks += int'(host_ack);
        end
        m_c = 16;
        m_b = 10;
        chk("host_single_ack", acks, 1);
        chk("host_busy", busy, 1);
        chk("host_contrast_not_yet", contrast, 4);
        while (o_c != m_c || o_b != m_b) frame();
        chk("host_contrast_clamped", contrast, 16);
        chk("host_brightness", brightness, 10);
        chk("host_busy_done", busy, 0);
    endtask

    task automatic test_saturation();
        host_write(16, 0);
        while (o_c != m_c || o_b != m_b) frame();
        chk("sat_brightness_zero", brightness, 0);
        pulse(3);
        tick();
        tick();
        chk("sat_bdn_floor_busy", busy, 0);
        btn_c_up = 1'b1;
        btn_c_dn = 1'b1;
        tick();
        {btn_c_up, btn_c_dn} = 2'b0;
        tick();
        tick();
        chk("sat_updn_busy", busy, 0);
        pulse(0);
        tick();
        tick();
        chk("sat_cup_ceiling_busy", busy, 0);
        chk("sat_contrast", contrast, 16);
    endtask

    task automatic test_cancel();
        int a0;
        a0 = apply_cnt;
        pulse(1);
        tick();
        chk("cancel_busy_rise", busy, 1);
        pulse(0);
        tick();
        chk("cancel_busy_fall", busy, 0);
        frame();
        chk("cancel_no_apply", apply_cnt - a0, 0);
        chk("cancel_contrast", contrast, 16);
    endtask

    task automatic test_reset_mid();
        pulse(2);
        tick();
        chk("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        #2;
        chk("mid_async_contrast", contrast, 4);
        chk("mid_async_brightness", brightness, 32);
        chk("mid_async_busy", busy, 0);
        tick();
        reset = 1'b1;
        m_c = 4; m_b = 32; o_c = 4; o_b = 32;
        repeat (2) tick();
        frame();
        chk("mid_targets_discarded", busy, 0);
        chk("mid_brightness_after_frame", brightness, 32);
    endtask

    task automatic test_ramp();
        int a0;
        a0 = apply_cnt;
        host_write(4, 36);
        tick();
`ifdef CB_RAMP_EN
        for (int i = 0; i < 4; i++) begin
            frame();
            chk("ramp_brightness_step", brightness, 33 + i);
            chk("ramp_busy", busy, (i < 3) ? 1 : 0);
        end
        chk("ramp_apply_pulses", apply_cnt - a0, 4);
`else
        frame();
        chk("ramp_brightness_jump", brightness, 36);
        chk("ramp_busy", busy, 0);
        chk("ramp_apply_pulses", apply_cnt - a0, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_bright_buttons();
        test_host_capture();
        test_saturation();
        test_cancel();
        test_reset_mid();
        test_ramp();
        repeat (4) tick();
        chk("sb_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
